// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// Front pipeline stage: owns the program counter, requests instructions from
// the instruction cache and hands {INSTRUCTION, PC_OUT, INSTRUCTION_VALID} to
// decode through a single output register.
//
// Cache handshake: INSTRUCTION_CACHE_READ is the request valid and
// INSTRUCTION_CACHE_READY is a one-cycle response strobe. A response is taken
// only at an edge where READ and READY are both high. The address equals pc
// and holds while READ is high and READY is low. READY is ignored while READ
// is low.
//
// States:
//   FETCH  - request outstanding at pc.
//   SQUASH - a redirect arrived while a request was in flight. Its response
//            must still be consumed (and dropped) before fetching at
//            redirect_pc.
//   BUFFER - a response arrived during a stall. It waits in a one-entry buffer
//            and no new request is issued.
//
// Optional feature: define FETCH_BUBBLE_COUNTER_EN to add BUBBLE_COUNT. It
// counts every edge at which the output register loads a bubble.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL_FETCH_STAGE,
    input  logic        CLEAR_FETCH_STAGE,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] INSTRUCTION_CACHE_ADDRESS,
    output logic        INSTRUCTION_CACHE_READ,
    input  logic        INSTRUCTION_CACHE_READY,
    input  logic [31:0] INSTRUCTION_CACHE_DATA,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic        INSTRUCTION_VALID,
    output logic [1:0]  FETCH_STATE
`ifdef FETCH_BUBBLE_COUNTER_EN
    ,
    output logic [31:0] BUBBLE_COUNT
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_BUFFER = 2'd2
    } state_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'h00000013;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_next;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        buf_load;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] target;
    logic [31:0] squash_target;
    logic        unused_target_bits;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign target             = {BRANCH_TARGET[31:2], 2'b00};
    assign unused_target_bits = ^BRANCH_TARGET[1:0];

    // A newer redirect seen in SQUASH overrides the stored one.
    assign squash_target = BRANCH_TAKEN ? target : redirect_pc;

    // The request is gated by reset, so it drops the moment reset asserts.
    assign INSTRUCTION_CACHE_READ    = RESET_N && (state != ST_BUFFER);
    assign INSTRUCTION_CACHE_ADDRESS = pc;
    assign FETCH_STATE               = state;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next pc, buffer load and delivery decisions
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = redirect_pc;
        buf_load      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = INSTRUCTION_CACHE_DATA;
        deliver_pc    = pc;
        case (state)
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (INSTRUCTION_CACHE_READY) begin
                        // The response that completes now belongs to the
                        // wrong path: drop it and restart at the target.
                        pc_next = target;
                    end else begin
                        redirect_next = target;
                        state_next    = ST_SQUASH;
                    end
                end else if (INSTRUCTION_CACHE_READY) begin
                    pc_next = pc + 32'd4;
                    if (STALL_FETCH_STAGE) begin
                        buf_load   = 1'b1;
                        state_next = ST_BUFFER;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            ST_SQUASH: begin
                if (BRANCH_TAKEN) begin
                    redirect_next = target;
                end
                if (INSTRUCTION_CACHE_READY) begin
                    pc_next    = squash_target;
                    state_next = ST_FETCH;
                end
            end
            ST_BUFFER: begin
                if (BRANCH_TAKEN) begin
                    pc_next    = target;
                    state_next = ST_FETCH;
                end else if (!STALL_FETCH_STAGE) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr;
                    deliver_pc    = buf_pc;
                    state_next    = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Program counter and pending redirect address
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc          <= RESET_PC;
            redirect_pc <= 32'h0;
        end else begin
            pc          <= pc_next;
            redirect_pc <= redirect_next;
        end
    end

    // One-entry buffer for a response that lands during a stall
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
        end else if (buf_load) begin
            buf_instr <= INSTRUCTION_CACHE_DATA;
            buf_pc    <= pc;
        end
    end

    // Decode-facing register: clear beats stall, stall beats a new delivery
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            INSTRUCTION       <= BUBBLE_INSTR;
            PC_OUT            <= 32'h0;
            INSTRUCTION_VALID <= 1'b0;
        end else if (CLEAR_FETCH_STAGE) begin
            INSTRUCTION       <= BUBBLE_INSTR;
            PC_OUT            <= 32'h0;
            INSTRUCTION_VALID <= 1'b0;
        end else if (STALL_FETCH_STAGE) begin
            INSTRUCTION       <= INSTRUCTION;
            PC_OUT            <= PC_OUT;
            INSTRUCTION_VALID <= INSTRUCTION_VALID;
        end else if (deliver) begin
            INSTRUCTION       <= deliver_instr;
            PC_OUT            <= deliver_pc;
            INSTRUCTION_VALID <= 1'b1;
        end else begin
            INSTRUCTION       <= BUBBLE_INSTR;
            PC_OUT            <= 32'h0;
            INSTRUCTION_VALID <= 1'b0;
        end
    end

`ifdef FETCH_BUBBLE_COUNTER_EN
    logic bubble_load;
    assign bubble_load = CLEAR_FETCH_STAGE || (!STALL_FETCH_STAGE && !deliver);

    // Count edges where the output register takes a bubble; wraps naturally
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BUBBLE_COUNT <= 32'h0;
        end else if (bubble_load) begin
            BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
        end
    end
`endif

endmodule
